encoder_reg_mc: RTL

Multi-channel, parametrised Avalon-MM register bank for the incremental-encoder capture path. It sits between the NIOS II Avalon bus and up to 16 encoder capture cores. It provides per-channel clear pulses, atomic snapshot latching of step/speed across all channels, per-channel step thresholds with a maskable level interrupt, and registered reads with a valid strobe.

---
 rtl/encoder_reg_mc.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/encoder_reg_mc.sv
// Avalon-MM register bank for the multi-channel incremental-encoder capture path.
// Global control/clear/irq registers at 0x00-0x04, four words per channel from 0x10.
module encoder_reg_mc #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               avs_address,
  input  logic                     avs_write,
  input  logic [31:0]              avs_write_data,
  input  logic                     avs_read,
  output logic [31:0]              avs_read_data,
  output logic                     avs_read_data_valid,
  output logic [CH_NUM-1:0]        clear,
  output logic                     irq,
  input  logic [CH_NUM*DATA_W-1:0] step,
  input  logic [CH_NUM*DATA_W-1:0] speed
);

  localparam logic [7:0]  ADDR_CTRL = 8'h00;
  localparam logic [7:0]  ADDR_CLR  = 8'h01;
  localparam logic [7:0]  ADDR_STAT = 8'h02;
  localparam logic [7:0]  ADDR_EN   = 8'h03;
  localparam logic [7:0]  ADDR_INFO = 8'h04;
  localparam logic [7:0]  ADDR_CH0  = 8'h10;
  localparam logic [31:0] INFO_WORD = {16'h0001, 8'(DATA_W), 8'(CH_NUM)};

  logic [DATA_W-1:0] step_ch    [CH_NUM];
  logic [DATA_W-1:0] speed_ch   [CH_NUM];
  logic [DATA_W-1:0] step_thr   [CH_NUM];
  logic [DATA_W-1:0] step_snap  [CH_NUM];
  logic [DATA_W-1:0] speed_snap [CH_NUM];

  logic [CH_NUM-1:0] hit;
  logic [CH_NUM-1:0] hit_q;
  logic [CH_NUM-1:0] hit_qq;
  logic [CH_NUM-1:0] evt;
  logic [CH_NUM-1:0] irq_stat;
  logic [CH_NUM-1:0] irq_en;
  logic [CH_NUM-1:0] clr_mask;
  logic [CH_NUM-1:0] w1c_mask;
  logic              ctrl_ie;

  logic              wr_ctrl;
  logic              wr_clr;
  logic              wr_stat;
  logic              wr_en;
  logic              snap_all;
  logic [5:0]        ch_idx;
  logic              ch_valid;
  logic [31:0]       rd_val;

  // Address decode shared by the write and read paths
  always_comb begin
    wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
    wr_clr   = avs_write && (avs_address == ADDR_CLR);
    wr_stat  = avs_write && (avs_address == ADDR_STAT);
    wr_en    = avs_write && (avs_address == ADDR_EN);
    snap_all = wr_ctrl && avs_write_data[1];
    ch_idx   = avs_address[7:2] - 6'd4;
    ch_valid = (avs_address >= ADDR_CH0) && (32'(ch_idx) < CH_NUM);
    clr_mask = {CH_NUM{wr_ctrl & avs_write_data[0]}}
             | ({CH_NUM{wr_clr}} & avs_write_data[CH_NUM-1:0]);
    w1c_mask = {CH_NUM{wr_stat}} & avs_write_data[CH_NUM-1:0];
  end

  // Unpack channel buses and evaluate the unsigned threshold compare
  always_comb begin
    for (int unsigned n = 0; n < CH_NUM; n++) begin
      step_ch[n]  = step[n*DATA_W +: DATA_W];
      speed_ch[n] = speed[n*DATA_W +: DATA_W];
      hit[n]      = (step_thr[n] != '0) && (step_ch[n] >= step_thr[n]);
    end
  end

  // Event is taken from the registered hit so IRQ_STAT lands one cycle after hit_q
  always_comb begin
    evt = hit_q & ~hit_qq;
  end

  // Global control state and one-cycle clear pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear   <= '0;
      ctrl_ie <= 1'b0;
      irq_en  <= '0;
    end else begin
      clear <= clr_mask;
      if (wr_ctrl) ctrl_ie <= avs_write_data[2];
      if (wr_en)   irq_en  <= avs_write_data[CH_NUM-1:0];
    end
  end

  // Per-channel thresholds and snapshots; a clear overrides a concurrent snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < CH_NUM; n++) begin
        step_thr[n]   <= '0;
        step_snap[n]  <= '0;
        speed_snap[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < CH_NUM; n++) begin
        if (avs_write && ch_valid && (32'(ch_idx) == n) && (avs_address[1:0] == 2'd2))
          step_thr[n] <= avs_write_data[DATA_W-1:0];
        if (clr_mask[n]) begin
          step_snap[n]  <= '0;
          speed_snap[n] <= '0;
        end else if (snap_all) begin
          step_snap[n]  <= step_ch[n];
          speed_snap[n] <= speed_ch[n];
        end
      end
    end
  end

  // Threshold edge detection, sticky status with set-over-W1C, registered irq level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q    <= '0;
      hit_qq   <= '0;
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      hit_q    <= hit;
      hit_qq   <= hit_q;
      irq_stat <= (irq_stat & ~w1c_mask) | evt;
      irq      <= ctrl_ie && (|(irq_stat & irq_en));
    end
  end

  // Read data mux; unmapped and out-of-range channel addresses return zero
  always_comb begin
    rd_val = '0;
    case (avs_address)
      ADDR_CTRL: rd_val[2] = ctrl_ie;
      ADDR_STAT: rd_val = 32'(irq_stat);
      ADDR_EN:   rd_val = 32'(irq_en);
      ADDR_INFO: rd_val = INFO_WORD;
      default: begin
        for (int unsigned n = 0; n < CH_NUM; n++) begin
          if (ch_valid && (32'(ch_idx) == n)) begin
            case (avs_address[1:0])
              2'd0:    rd_val = 32'(step_snap[n]);
              2'd1:    rd_val = 32'(speed_snap[n]);
              2'd2:    rd_val = 32'(step_thr[n]);
              default: rd_val = 32'(step_ch[n]);
            endcase
          end
        end
      end
    endcase
  end

  // Registered read response; reads see register state from before any same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avs_read_data       <= '0;
      avs_read_data_valid <= 1'b0;
    end else begin
      avs_read_data       <= avs_read ? rd_val : '0;
      avs_read_data_valid <= avs_read;
    end
  end

endmodule
